// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the Writeback
//   stage (fixed priority, never back-pressured) and a long-latency unit
//   whose results wait in a small FIFO. Queued results are written on the
//   cycles when Writeback does not use the port.
//
// Handshake (lu_*): a result transfers on any cycle where lu_valid and
//   lu_ready are both high. lu_ready is !full, derived from the stored count
//   only, so a full FIFO refuses input even on a cycle it also drains.
//   A result for x0 transfers but is discarded.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_we, wb_rd, wb_wd       Writeback write request (zero latency)
//   lu_valid, lu_rd, lu_wd    long-latency result in
//   lu_ready                  FIFO can accept
//   rf_we, rf_a3, rf_wd       register file write port (WE3/A3/WD3)
//   busy_mask                 bit r set while a live queued entry targets xr
//   fifo_count                number of valid FIFO entries
//   stall_o                   registered request to bubble Writeback
//
// Optional build macro RFARB_WAW_KILL_EN: a Writeback to rd kills every
//   queued entry targeting the same rd. Killed entries still drain in order
//   but do not write and do not show in busy_mask.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_wd,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_wd,
  output logic                     lu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_a3,
  output logic [31:0]              rf_wd,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] MAX_W    = WW'(MAX_WAIT);

  logic [4:0]    rd_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_live;

  logic wb_active, empty, full, enq_hs, enq, deq;

  assign wb_active = wb_we && (wb_rd != 5'd0);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign lu_ready  = !full;
  assign enq_hs    = lu_valid && lu_ready;
  assign enq       = enq_hs && (lu_rd != 5'd0);
  // The head drains on any cycle Writeback leaves the port idle.
  assign deq       = !wb_active && !empty;

  // A slot is valid when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
    end
  end

`ifdef RFARB_WAW_KILL_EN
  logic [DEPTH-1:0] dead_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dead_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_active && slot_valid[i] && (rd_q[i] == wb_rd)) dead_q[i] <= 1'b1;
      end
      // The incoming entry is younger than this cycle's Writeback, so it lives.
      if (enq) dead_q[wr_ptr_q] <= 1'b0;
    end
  end

  assign slot_live = slot_valid & ~dead_q;
`else
  assign slot_live = slot_valid;
`endif

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_live[i]) busy_mask[rd_q[i]] = 1'b1;
    end
  end

  // Write port mux: Writeback first, then the FIFO head.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (wb_active) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_wd;
    end else if (deq && slot_live[rd_ptr_q]) begin
      rf_we = 1'b1;
      rf_a3 = rd_q[rd_ptr_q];
      rf_wd = wd_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Starvation: count cycles the head is stuck behind Writeback.
  always_comb begin
    wait_d  = wait_q;
    stall_d = stall_q;
    if (empty || deq) begin
      wait_d = '0;
    end else if (wait_q != MAX_W) begin
      wait_d = wait_q + 1'b1;
    end
    if (deq) begin
      stall_d = 1'b0;
    end else if (wait_d == MAX_W) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[wr_ptr_q] <= lu_rd;
      wd_q[wr_ptr_q] <= lu_wd;
    end
  end

  assign fifo_count = count_q;
  assign stall_o    = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wd = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_wd = '0;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;
  logic        stall_o;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .busy_mask(busy_mask), .fifo_count(fifo_count), .stall_o(stall_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: queue of pending results plus starvation state
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          dead;
  } ent_t;

  ent_t mq[$];
  int   m_wait  = 0;
  bit   m_stall = 1'b0;

  // scoreboard of expected register-file writes {a3, wd}
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (!mq[i].dead) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // driver: one clock cycle of stimulus, with model bookkeeping
  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    bit wb_act, drain, acc;
    @(negedge clk);
    wb_we = we; wb_rd = rd; wb_wd = wd;
    lu_valid = lv; lu_rd = lrd; lu_wd = lwd;
    #1;
    chk("fifo_count", 37'(fifo_count), 37'(mq.size()));
    chk("busy_mask",  37'(busy_mask),  37'(model_busy()));
    chk("lu_ready",   37'(lu_ready),   37'(mq.size() < DEPTH));
    chk("stall_o",    37'(stall_o),    37'(m_stall));
    wb_act = we && (rd != 5'd0);
    drain  = !wb_act && (mq.size() != 0);
    acc    = lv && (mq.size() < DEPTH);
    if (wb_act) exp_q.push_back({rd, wd});
    else if (drain && !mq[0].dead) exp_q.push_back({mq[0].rd, mq[0].wd});
`ifdef RFARB_WAW_KILL_EN
    if (wb_act) foreach (mq[i]) if (mq[i].rd == rd) mq[i].dead = 1'b1;
`endif
    if ((mq.size() == 0) || drain) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    if (drain) m_stall = 1'b0;
    else if (m_wait == MAX_WAIT) m_stall = 1'b1;
    if (drain) void'(mq.pop_front());
    if (acc && (lrd != 5'd0)) mq.push_back('{rd: lrd, wd: lwd, dead: 1'b0});
  endtask

  // asynchronous reset between clock edges; state must clear immediately
  task automatic do_reset();
    @(negedge clk);
    wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_fifo_count", 37'(fifo_count), 37'(0));
    chk("rst_busy_mask",  37'(busy_mask),  37'(0));
    chk("rst_lu_ready",   37'(lu_ready),   37'(1));
    chk("rst_stall_o",    37'(stall_o),    37'(0));
    mq.delete();
    m_wait  = 0;
    m_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: compares the write port against the scoreboard every cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got a3=%0d wd=0x%0h, expected no write at %0t",
                   rf_a3, rf_wd, $time);
        end else begin
          chk("rf_write", {rf_a3, rf_wd}, exp_q.pop_front());
        end
      end else begin
        chk("idle_port", {rf_a3, rf_wd}, 37'(0));
        chk("missing_write", 37'(exp_q.size()), 37'(0));
        exp_q.delete();
      end
    end
  end

  initial begin
    int k;
    bit acc_pred;
    logic we_r;

    do_reset();

    // Writeback zero-latency path
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);

    // single long-latency result: queue, then drain
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // fill behind a busy Writeback, fifth offer waits for space
    k = 0;
    for (int c = 0; c < 12; c++) begin
      acc_pred = (mq.size() < DEPTH);
      cycle(c < 6, 5'd3, $urandom, k < 5, 5'(10 + k), 32'(100 + k));
      if (acc_pred && (k < 5)) k++;
    end

    // starvation: one entry blocked for MAX_WAIT cycles and beyond
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hABC);
    for (int c = 0; c < MAX_WAIT + 1; c++) cycle(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // x0 results are discarded; Writeback to x0 leaves the port idle
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    cycle(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Writeback to the same rd as a queued entry
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    cycle(1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // reset with entries buffered
    for (int c = 0; c < 3; c++) cycle(1'b1, 5'd2, $urandom, 1'b1, 5'(11 + c), $urandom);
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // randomized traffic; Writeback mostly honours stall_o
    for (int c = 0; c < 400; c++) begin
      if (m_stall) we_r = ($urandom_range(0, 9) == 0);
      else         we_r = ($urandom_range(0, 2) != 0);
      cycle(we_r, 5'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
      if (c == 200) do_reset();
    end

    for (int c = 0; c < 8; c++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
